// File: rtl/evm_pkg.sv
// Shared types and status-word layout for the voter memory read side.
// Status word is {voted_flag, voter_id[2:0]}.
package evm_pkg;

  localparam int VOTED_BIT = 3;
  localparam int ID_MSB    = 2;
  localparam int ADDR_W    = ID_MSB + 1;
  localparam int WORD_W    = VOTED_BIT + 1;

  typedef enum logic [2:0] {
    IDLE,
    Q_READ,
    Q_WAIT,
    Q_RESP,
    S_READ,
    S_WAIT,
    S_DONE
  } state_e;

  // Exactly one field is set for any decoded word.
  typedef struct packed {
    logic eligible;
    logic duplicate;
    logic mismatch;
  } resp_code_t;

endpackage

// File: rtl/voter_status_reader_if.sv
// Query handshake between the ballot-unit controller (master) and the
// voter status reader (slave).
interface voter_status_reader_if;
  import evm_pkg::*;

  logic              req_valid;
  logic [ADDR_W-1:0] req_voter;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_eligible;
  logic              resp_duplicate;
  logic              resp_mismatch;

  modport master (
    output req_valid, req_voter,
    input  req_ready, resp_valid, resp_eligible, resp_duplicate, resp_mismatch
  );

  modport slave (
    input  req_valid, req_voter,
    output req_ready, resp_valid, resp_eligible, resp_duplicate, resp_mismatch
  );

endinterface

// File: rtl/status_word_decoder.sv
// Combinational decode of one status word against an expected voter id.
// Used for query responses and for the voted flag during an audit scan.
module status_word_decoder
  import evm_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [ADDR_W-1:0] id,
  output resp_code_t        code,
  output logic              voted
);

  assign voted          = word[VOTED_BIT];
  assign code.mismatch  = (word[ID_MSB:0] != id);
  assign code.duplicate =  word[VOTED_BIT] & ~code.mismatch;
  assign code.eligible  = ~word[VOTED_BIT] & ~code.mismatch;

endmodule

// File: rtl/voter_status_reader.sv
// Read-only front end of the voter memory: eligibility queries and turnout scan.
// Optional LOCKOUT_EN: third duplicate response raises a sticky tamper alarm and blocks queries.
module voter_status_reader
  import evm_pkg::*;
#(
  parameter int NUM_VOTERS = 8,
  parameter int CNT_W      = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  voter_status_reader_if.slave  bus,
  input  logic                  scan_start,
  output logic                  scan_busy,
  output logic                  scan_done,
  output logic [CNT_W-1:0]      turnout_count,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [WORD_W-1:0]     mem_rd_data,
  output logic                  tamper_alarm
);

  localparam logic [1:0]        LAST_WAIT = 2'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_VOTERS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        wait_q, wait_d;
  logic [CNT_W-1:0]  count_q, count_d;
  resp_code_t        code_q, code_d;

  resp_code_t dec_code;
  logic       dec_voted;
  logic       ready_idle;
  logic       resp_strobe;

  // The address register holds the latched query id or the scan pointer.
  status_word_decoder u_decoder (
    .word  (mem_rd_data),
    .id    (addr_q),
    .code  (dec_code),
    .voted (dec_voted)
  );

  assign ready_idle = (state_q == IDLE);

  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    wait_d      = wait_q;
    count_d     = count_q;
    code_d      = code_q;
    mem_rd_en   = 1'b0;
    scan_busy   = 1'b0;
    scan_done   = 1'b0;
    resp_strobe = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          addr_d = bus.req_voter;
          if (int'(bus.req_voter) >= NUM_VOTERS) begin
            code_d  = '{eligible: 1'b0, duplicate: 1'b0, mismatch: 1'b1};
            state_d = Q_RESP;
          end else begin
            state_d = Q_READ;
          end
        end else if (scan_start) begin
          count_d = '0;
          addr_d  = '0;
          state_d = S_READ;
        end
      end
      Q_READ: begin
        mem_rd_en = 1'b1;
        wait_d    = '0;
        state_d   = Q_WAIT;
      end
      Q_WAIT: begin
        if (wait_q == LAST_WAIT) begin
          code_d  = dec_code;
          state_d = Q_RESP;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      Q_RESP: begin
        resp_strobe = 1'b1;
        state_d     = IDLE;
      end
      S_READ: begin
        scan_busy = 1'b1;
        mem_rd_en = 1'b1;
        wait_d    = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        scan_busy = 1'b1;
        if (wait_q == LAST_WAIT) begin
          if (dec_voted && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
          end
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_DONE: begin
        scan_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wait_q  <= '0;
      count_q <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      code_q  <= code_d;
    end
  end

  assign mem_rd_addr        = addr_q;
  assign turnout_count      = count_q;
  assign bus.resp_valid     = resp_strobe;
  assign bus.resp_eligible  = resp_strobe & code_q.eligible;
  assign bus.resp_duplicate = resp_strobe & code_q.duplicate;
  assign bus.resp_mismatch  = resp_strobe & code_q.mismatch;

`ifdef LOCKOUT_EN
  logic [1:0] dup_cnt_q, dup_cnt_d;
  logic       alarm_q, alarm_d;

  always_comb begin
    dup_cnt_d = dup_cnt_q;
    alarm_d   = alarm_q;
    if (resp_strobe && code_q.duplicate) begin
      if (dup_cnt_q == 2'd2) alarm_d = 1'b1;
      if (dup_cnt_q != 2'd3) dup_cnt_d = dup_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dup_cnt_q <= '0;
      alarm_q   <= 1'b0;
    end else begin
      dup_cnt_q <= dup_cnt_d;
      alarm_q   <= alarm_d;
    end
  end

  assign bus.req_ready = ready_idle & ~alarm_q;
  assign tamper_alarm  = alarm_q;
`else
  assign bus.req_ready = ready_idle;
  assign tamper_alarm  = 1'b0;
`endif

endmodule
